// File: rtl/tape_pkg.sv
// tape_pkg: shared FSM states, CSW constants and saturating add for the tape recorder
package tape_pkg;
  typedef enum logic [2:0] {IDLE, ARMED, COUNT, EMIT, DRAIN} state_t;
  localparam logic [7:0] CSW_LONG_MARK = 8'h00;
  localparam logic [31:0] CSW_SHORT_MAX = 32'd255;
  function automatic logic [31:0] sat_add(input logic [31:0] a, input logic [31:0] b);
    logic [32:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[32] ? 32'hFFFF_FFFF : s[31:0];
  endfunction
endpackage

// File: rtl/tape_recorder_if.sv
// tape_recorder_if: tape buffer write port (request held until a one-cycle ack)
//   buff_wr   write request
//   buff_addr byte offset in the tape buffer
//   buff_dout byte to write
//   buff_ack  current byte accepted
interface tape_recorder_if;
  logic buff_wr;
  logic [21:0] buff_addr;
  logic [7:0] buff_dout;
  logic buff_ack;
  modport master (output buff_wr, buff_addr, buff_dout, input buff_ack);
  modport slave (input buff_wr, buff_addr, buff_dout, output buff_ack);
endinterface

// File: rtl/tape_fifo.sv
// tape_fifo: synchronous byte FIFO, 2^AW deep, async active-high reset
//   push/din  write side (ignored when full unless popping in the same cycle)
//   pop/dout  show-ahead read side
//   full/empty status flags
module tape_fifo #(
  parameter int AW = 3
) (
  input  logic       clk_sys,
  input  logic       reset,
  input  logic       push,
  input  logic       pop,
  input  logic [7:0] din,
  output logic [7:0] dout,
  output logic       full,
  output logic       empty
);
  logic [7:0] mem [2**AW];
  logic [AW:0] wp, rp;
  logic do_push, do_pop;
  assign empty = wp == rp;
  assign full = (wp[AW] != rp[AW]) && (wp[AW-1:0] == rp[AW-1:0]);
  assign dout = mem[rp[AW-1:0]];
  assign do_push = push && (!full || pop);
  assign do_pop = pop && !empty;
  always_ff @(posedge clk_sys or posedge reset)
    if (reset) begin
      wp <= '0;
      rp <= '0;
    end else begin
      if (do_push) wp <= wp + 1'b1;
      if (do_pop) rp <= rp + 1'b1;
    end
  always_ff @(posedge clk_sys)
    if (do_push) mem[wp[AW-1:0]] <= din;
endmodule

// File: rtl/tape_recorder.sv
// tape_recorder: CSW v1 run-length encoder writing MIC run lengths into the tape buffer
//   clk_sys, reset  system clock, async active-high reset
//   ce              3.5 MHz clock-enable strobe, divided by CE_DIV into sample periods
//   mic, rec        MIC level input, record enable level
//   buff            tape buffer write port (master)
//   size            bytes committed; busy: not idle; full/overflow: sticky status
module tape_recorder #(
  parameter int          CE_DIV   = 80,
  parameter logic [21:0] MAX_SIZE = 22'h3FFFFF,
  parameter int          FIFO_AW  = 3
) (
  input  logic                   clk_sys,
  input  logic                   reset,
  input  logic                   ce,
  input  logic                   mic,
  input  logic                   rec,
  tape_recorder_if.master        buff,
  output logic [21:0]            size,
  output logic                   busy,
  output logic                   full,
  output logic                   overflow
);
  import tape_pkg::*;
  localparam int CW = CE_DIV > 1 ? $clog2(CE_DIV) : 1;
  state_t state;
  logic [CW-1:0] cnt;
  logic [2:0] mic_q;
  logic rec_q, pend, stop;
  logic [31:0] run, len, pend_len, run_now, ended;
  logic [2:0] idx;
  logic tick, edge_det, is_long, last, push, pop, drop, f_full, f_empty;
  logic [7:0] byte_out, f_dout;
  assign tick = ce && cnt == CW'(CE_DIV - 1);
  assign edge_det = mic_q[1] ^ mic_q[2];
  // a tick coinciding with an edge belongs to the run that edge ends
  assign run_now = tick ? sat_add(run, 32'd1) : run;
  assign ended = run_now == 32'd0 ? 32'd1 : run_now;
  assign is_long = len > CSW_SHORT_MAX;
  assign last = !is_long || idx == 3'd4;
  assign byte_out = idx == 3'd0 ? (is_long ? CSW_LONG_MARK : len[7:0]) :
                    idx == 3'd1 ? len[7:0] :
                    idx == 3'd2 ? len[15:8] :
                    idx == 3'd3 ? len[23:16] : len[31:24];
  assign push = state == EMIT;
  // once full, bytes keep being popped and silently discarded
  assign pop = !f_empty && !buff.buff_wr;
  assign drop = push && f_full && !pop;
  tape_fifo #(.AW(FIFO_AW)) u_fifo (
    .clk_sys(clk_sys), .reset(reset), .push(push), .pop(pop),
    .din(byte_out), .dout(f_dout), .full(f_full), .empty(f_empty)
  );
  always_ff @(posedge clk_sys or posedge reset)
    if (reset) begin
      state <= IDLE;
      cnt <= '0;
      mic_q <= '0;
      rec_q <= 1'b0;
      pend <= 1'b0;
      stop <= 1'b0;
      run <= '0;
      len <= '0;
      pend_len <= '0;
      idx <= '0;
      size <= '0;
      busy <= 1'b0;
      full <= 1'b0;
      overflow <= 1'b0;
      buff.buff_wr <= 1'b0;
      buff.buff_addr <= '0;
      buff.buff_dout <= '0;
    end else begin
      mic_q <= {mic_q[1:0], mic};
      rec_q <= rec;
      if (ce) cnt <= tick ? '0 : cnt + 1'b1;
      if (drop) overflow <= 1'b1;
      if (buff.buff_wr && buff.buff_ack) begin
        buff.buff_wr <= 1'b0;
        size <= size + 1'b1;
        if (size + 1'b1 == MAX_SIZE) full <= 1'b1;
      end else if (pop && !full) begin
        buff.buff_wr <= 1'b1;
        buff.buff_addr <= size;
        buff.buff_dout <= f_dout;
      end
      case (state)
        IDLE: if (rec && !rec_q) begin
          state <= ARMED;
          busy <= 1'b1;
          size <= '0;
          full <= 1'b0;
          overflow <= 1'b0;
          buff.buff_addr <= '0;
          cnt <= '0;
          pend <= 1'b0;
          stop <= 1'b0;
        end
        ARMED: if (edge_det) begin
          run <= '0;
          state <= COUNT;
        end else if (!rec) state <= DRAIN;
        COUNT: begin
          run <= edge_det ? '0 : run_now;
          if (edge_det) begin
            len <= ended;
            idx <= '0;
            state <= EMIT;
          end else if (!rec) begin
            if (run_now != 32'd0) begin
              len <= run_now;
              idx <= '0;
              stop <= 1'b1;
              state <= EMIT;
            end else state <= DRAIN;
          end
        end
        EMIT: begin
          run <= edge_det ? '0 : run_now;
          if (!last) begin
            idx <= idx + 1'b1;
            if (edge_det) begin
              pend <= 1'b1;
              pend_len <= pend ? sat_add(pend_len, ended) : ended;
              if (pend) overflow <= 1'b1;
            end
          end else if (pend || edge_det) begin
            // chain straight into the next length without returning to COUNT
            len <= pend ? pend_len : ended;
            idx <= '0;
            pend <= pend && edge_det;
            pend_len <= ended;
          end else state <= stop ? DRAIN : COUNT;
        end
        DRAIN: if (f_empty && !buff.buff_wr) begin
          busy <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
endmodule

// File: doc/tape_recorder.md
Name: tape_recorder

Overview:
- CSW v1 run-length encoder: the record side of the tape path, the counterpart to the tape player that decodes CSW from SDRAM.
- Samples the ULA MIC output bit, measures the time between level changes in sample periods, and encodes each run as CSW RLE bytes.
- Writes the bytes sequentially into the SDRAM tape buffer through a request/ack port arbitrated in the top level.
- Host retrieves the buffer and prepends the CSW header; the block writes body data only.

Parameters:
- CE_DIV, 80, ce ticks per sample period (3.5 MHz / 80 = 43750 Hz).
- MAX_SIZE, 22'h3FFFFF, maximum body size in bytes; writes stop at this count.
- FIFO_AW, 3, byte FIFO address width (depth 8).

Ports:
- clk_sys  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- ce  in  1  CPU clock-enable strobe (3.5 MHz-equivalent).
- mic  in  1  ULA MIC output level.
- rec  in  1  level; 1 = recording armed/running, 0 = stop.
- buff_wr  out  1  write request, held until buff_ack.
- buff_addr  out  22  byte offset in the tape buffer.
- buff_dout  out  8  byte to write.
- buff_ack  in  1  one-cycle strobe: current byte accepted.
- size  out  22  bytes committed so far.
- busy  out  1  recording or draining.
- full  out  1  sticky: MAX_SIZE reached.
- overflow  out  1  sticky: FIFO full, byte dropped.

Behaviour:
- Reset values: buff_wr=0, buff_addr=0, buff_dout=0, size=0, busy=0, full=0, overflow=0. FSM goes to IDLE and the FIFO empties. A reset mid-operation discards all pending bytes.
- Prescaler:
  - Counts ce pulses 0..CE_DIV-1.
  - sample_tick is asserted on the ce where the prescaler wraps.
  - The prescaler is cleared on entry to ARMED.
- mic is registered twice (synchroniser). An edge is a change of the registered level, evaluated every clk_sys.
- FSM states and transitions:
  - IDLE: on rising rec, clear size, full, overflow and addr, then go to ARMED.
  - ARMED: wait for the first mic edge; the leading silence is not recorded. Edge: run=0, go to COUNT. rec=0: go to DRAIN.
  - COUNT:
    - run increments on sample_tick and saturates at 32'hFFFFFFFF.
    - On an edge, len = (run==0) ? 1 : run; run restarts at 0 in the same cycle, and the FSM emits.
    - If an edge and a sample_tick occur in the same cycle, the tick counts toward the ending run.
    - rec=0: emit the final run if run>0, then go to DRAIN.
  - Emit:
    - len 1..255: push one byte, len[7:0].
    - len ≥256: push 5 bytes, 8'h00 then len[7:0], len[15:8], len[23:16], len[31:24].
    - The pushes take one clk_sys cycle each. The FSM returns to COUNT while run keeps counting.
    - Edges during emit are not lost: up to 1 pending length is latched.
    - A second edge while one is already pending sets overflow and merges the runs.
  - DRAIN: busy stays 1 until the FIFO is empty and no write is outstanding, then go to IDLE.
- busy=1 in every state except IDLE.
- FIFO:
  - Push when full drops the byte and sets overflow.
  - Simultaneous push and pop when full is permitted.
- Write port:
  - When the FIFO is not empty and not full-flagged, pop into buff_dout, set buff_addr=size, and assert buff_wr.
  - Hold buff_wr, buff_addr and buff_dout stable until buff_ack.
  - On buff_ack: buff_wr=0 and size increments. The next request may assert on the following cycle.
- Size limit:
  - When size reaches MAX_SIZE, set full. No further buff_wr is issued; further bytes are popped and discarded.
  - Recording continues until rec falls.
- rec rising while in DRAIN is ignored; it must be re-asserted after IDLE.

Decomposition:
- Shared package tape_pkg holds:
  - the state enum (IDLE, ARMED, COUNT, EMIT, DRAIN);
  - the CSW_LONG_MARK = 8'h00 constant;
  - the CSW_SHORT_MAX = 255 constant.
- One sub-module, tape_fifo: synchronous byte FIFO, 2^FIFO_AW deep, with full/empty flags, using the same clock and asynchronous reset.

Test Plan:
- Short pulses: CE_DIV=80, rec=1; toggle mic every 800 ce for 4 edges; ack every request after 3 cycles -> bytes 0x0A, 0x0A, 0x0A at addr 0,1,2; size=3 after rec=0 and drain; busy falls.
- Long run: after the first edge, hold mic 300 samples (24000 ce), then toggle -> bytes 00 2C 01 00 00 at addr 0..4; size=5.
- Sub-sample edge: two edges 10 ce apart -> byte 0x01 emitted.
- Backpressure: never ack, generate 12 short pulses -> buff_wr held with addr 0; FIFO fills; overflow=1; after acks resume, exactly 9 bytes are written (1 in the output register + 8 in the FIFO).
- Limit: MAX_SIZE=4, 6 short pulses with immediate ack -> 4 writes, full=1, size=4, no buff_wr afterwards.
- Reset mid-write: assert reset while buff_wr=1 -> all outputs 0 asynchronously; after release with rec=0 the block stays IDLE with no writes.
